alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's combinational 16-bit flag adder.
- Registered multi-op ALU of width WIDTH. Single-cycle ops: ADD, SUB, ADC, AND, OR, XOR, SHL, SHR. Multi-cycle op: MUL (unsigned shift-add).
- Produces the same five status flags (sign, zero, parity, carry, overflow) plus a persistent carry flag for chained ADC.
- Sits between the operand-fetch stage and writeback; valid/ready on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4).
- SHW, $clog2(WIDTH), shift-amount width; taken from y[SHW-1:0].

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  4  alu_pkg::alu_op_e.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B (shift amount for SHL/SHR).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- z  output  WIDTH  result.
- sign  output  1  z[WIDTH-1].
- zero  output  1  z == 0.
- parity  output  1  even parity: 1 when popcount(z) is even.
- carry  output  1  carry-out (ADD/ADC), borrow (SUB), last bit shifted out (SHL/SHR), high half ≠ 0 (MUL); 0 for logic ops.
- overflow  output  1  signed overflow for ADD/ADC/SUB; equals carry for MUL; 0 otherwise.
- busy  output  1  MUL in progress.

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0; z=0; all flags=0; carry_q=0; busy=0. in_ready=0 while rst is high.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output retired when out_valid && out_ready.
  - z and flags hold stable while out_valid=1 and out_ready=0.
- FSM states:
  - IDLE: in_ready=1. On accept of a non-MUL op, result is registered and the FSM goes to DONE (out_valid=1 next cycle, latency 1). On accept of MUL, go to MUL_BUSY.
  - MUL_BUSY: in_ready=0, busy=1. Runs one shift-add step per cycle for exactly WIDTH cycles, then goes to DONE. MUL latency is WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1. in_ready=out_ready, so a back-to-back accept is allowed in the retire cycle. On retire with no new accept, go to IDLE. On retire with a new accept, go to the new op's next state (DONE or MUL_BUSY) without an idle bubble.
- Arithmetic:
  - Computed at WIDTH+1 bits; {carry, z} = x + y (+ carry_q for ADC).
  - SUB: z = x − y; carry = borrow (x < y, unsigned).
  - Overflow:
    - ADD/ADC: (x[msb] & y[msb] & ~z[msb]) | (~x[msb] & ~y[msb] & z[msb]).
    - SUB: (x[msb] ^ y[msb]) & (x[msb] ^ z[msb]).
  - Shifts are logical. A shift amount of 0 gives z=x, carry=0.
  - MUL: full 2·WIDTH product internally; z = low WIDTH bits.
- Carry flag (carry_q):
  - Updated only when an ADD, ADC, or SUB result is registered; it takes that op's carry.
  - Other ops leave it unchanged.
  - ADC uses the carry_q value at the accept cycle.
- Illegal op codes: treated as ADD with carry_q unaffected, and flagged by an SVA assertion.
- Operands are latched at accept; changing x, y, or op afterwards has no effect.
- Reset mid-MUL aborts the multiply: no out_valid is produced and all state clears.

Decomposition:
- alu_pkg contains:
  - typedef enum logic [3:0] alu_op_e: ADD=0, SUB=1, ADC=2, AND=3, OR=4, XOR=5, SHL=6, SHR=7, MUL=8.
  - typedef enum alu_state_e: IDLE, MUL_BUSY, DONE.
  - A flag struct alu_flags_t {sign, zero, parity, carry, overflow}.
- One sub-module: seq_multiplier. It is the WIDTH-cycle shift-add unit with start/done, parametrised by WIDTH, and returns a 2·WIDTH product.

Test Plan:
- Reset then ADD x=0x8FFF, y=0x8000 → one cycle later out_valid=1, z=0x0FFF, carry=1, overflow=1, sign=0, zero=0, parity=1.
- SUB x=0x0005, y=0x0007, then ADC x=0x0001, y=0x0001 → first result z=0xFFFE, carry=1, sign=1, overflow=0; ADC result z=0x0003, carry=0.
- MUL x=0x0100, y=0x0100 → busy for 16 cycles, out_valid at cycle 17, z=0x0000, zero=1, carry=1, overflow=1; in_ready=0 throughout.
- Backpressure: XOR x=0xFFFF, y=0x00FF with out_ready=0 for 5 cycles → z=0xFF00 held stable, in_ready=0. Then raise out_ready together with an AND request → retire and accept in the same cycle; next z=AND result with no bubble.
- Shift: SHL x=0x8001, y=1 → z=0x0002, carry=1; SHR x=0x0001, y=0 → z=0x0001, carry=0.
- Reset mid-MUL: assert rst 5 cycles into a MUL → out_valid never rises, busy=0 immediately, carry_q=0; a subsequent ADD behaves as after power-on.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the status flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        ADC = 4'd2,
        AND = 4'd3,
        OR  = 4'd4,
        XOR = 4'd5,
        SHL = 4'd6,
        SHR = 4'd7,
        MUL = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic sign;
        logic zero;
        logic parity;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// Unsigned shift-add multiplier: one partial-product step per cycle for WIDTH cycles.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] step;

    // Upper half accumulates the multiplicand; the multiplier drains out of the low half.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        step    = {partial, prod_q[WIDTH-1:1]};
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        if (start) begin
            prod_d  = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            cnt_d   = '0;
            run_d   = 1'b1;
        end else if (run_q) begin
            prod_d = step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    // The final step's result is handed over in the same cycle it is computed.
    assign done    = run_q && (cnt_q == LAST);
    assign product = step;

endmodule

// File: rtl/alu_seq.sv
// Registered multi-op ALU with valid/ready on both sides; MUL is delegated to seq_multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             parity,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   z_q, z_d;
    alu_flags_t         flags_q, flags_d;
    logic               carry_q, carry_d;
    alu_op_e            op_e;
    logic               accept;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_hi;

    logic [WIDTH:0]     sum, diff, shl_w, shr_w;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   res_z;
    logic               res_c, res_v, res_upd;

    function automatic alu_flags_t flags_of(logic [WIDTH-1:0] r, logic c, logic v);
        return '{sign: r[WIDTH-1], zero: (r == '0), parity: ~^r, carry: c, overflow: v};
    endfunction

    assign op_e     = alu_op_e'(op);
    assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (x),
        .b       (y),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_hi = |mul_product[2*WIDTH-1:WIDTH];

    // Single-cycle datapath; unknown codes fall through as a plain ADD that leaves carry_q alone.
    always_comb begin
        sh      = y[SHW-1:0];
        sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, (op_e == ADC) & carry_q};
        diff    = {1'b0, x} - {1'b0, y};
        shl_w   = {1'b0, x} << sh;
        shr_w   = {x, 1'b0} >> sh;
        res_z   = sum[WIDTH-1:0];
        res_c   = sum[WIDTH];
        res_v   = (x[WIDTH-1] & y[WIDTH-1] & ~sum[WIDTH-1]) | (~x[WIDTH-1] & ~y[WIDTH-1] & sum[WIDTH-1]);
        res_upd = 1'b0;
        case (op_e)
            ADD, ADC: res_upd = 1'b1;
            SUB: begin
                res_z   = diff[WIDTH-1:0];
                res_c   = diff[WIDTH];
                res_v   = (x[WIDTH-1] ^ y[WIDTH-1]) & (x[WIDTH-1] ^ diff[WIDTH-1]);
                res_upd = 1'b1;
            end
            AND: begin res_z = x & y; res_c = 1'b0; res_v = 1'b0; end
            OR:  begin res_z = x | y; res_c = 1'b0; res_v = 1'b0; end
            XOR: begin res_z = x ^ y; res_c = 1'b0; res_v = 1'b0; end
            SHL: begin res_z = shl_w[WIDTH-1:0]; res_c = shl_w[WIDTH]; res_v = 1'b0; end
            SHR: begin res_z = shr_w[WIDTH:1];   res_c = shr_w[0];     res_v = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        z_d       = z_q;
        flags_d   = flags_q;
        carry_d   = carry_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // In DONE the result is only released (and a new op taken) once out_ready is seen.
                if (state_q == IDLE || out_ready) begin
                    if (accept) begin
                        if (op_e == MUL) begin
                            state_d   = MUL_BUSY;
                            mul_start = 1'b1;
                        end else begin
                            state_d = DONE;
                            z_d     = res_z;
                            flags_d = flags_of(res_z, res_c, res_v);
                            if (res_upd) carry_d = res_c;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d = DONE;
                    z_d     = mul_product[WIDTH-1:0];
                    flags_d = flags_of(mul_product[WIDTH-1:0], mul_hi, mul_hi);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            z_q     <= '0;
            flags_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            flags_q <= flags_d;
            carry_q <= carry_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL_BUSY);
    assign z         = z_q;
    assign sign      = flags_q.sign;
    assign zero      = flags_q.zero;
    assign parity    = flags_q.parity;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;

    illegal_op_a: assert property (@(posedge clk) disable iff (rst) accept |-> (op <= 4'd8))
        else $error("alu_seq: illegal op code 0x%0h accepted", op);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: stimulus pushes expected results, a negedge monitor retires and compares.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] x, y, z;
    logic         sign, zero, parity, carry, overflow, busy;

    typedef struct {
        string        name;
        logic [W-1:0] z;
        logic [4:0]   f;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .sign      (sign),
        .zero      (zero),
        .parity    (parity),
        .carry     (carry),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags are listed as {sign, zero, parity, carry, overflow}.
    task automatic expect_result(input string name, input logic [W-1:0] ez, input logic [4:0] ef);
        exp_t e;
        e.name = name;
        e.z    = ez;
        e.f    = ef;
        sb_q.push_back(e);
    endtask

    // Called half a step after a rising edge; returns half a step after the accepting edge.
    task automatic send(input alu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        op = o;
        x = a;
        y = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", o);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = W'($urandom);
        y = W'($urandom);
        op = 4'($urandom_range(0, 8));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got z=0x%0h expected no result", z);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_z"}, 32'(z), 32'(e.z));
                check({e.name, "_flags"}, 32'({sign, zero, parity, carry, overflow}), 32'(e.f));
            end
        end
    end

    initial begin
        int n, busy_cnt, ready_cnt, bad_z, bad_v, bad_r, ov_cnt;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 4'd0;
        x = '0;
        y = '0;

        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_z", 32'(z), 32'd0);
        check("reset_flags", 32'({sign, zero, parity, carry, overflow}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // ADD with carry and signed overflow, latency one cycle
        @(posedge clk);
        #1;
        expect_result("add", 16'h0FFF, 5'b00111);
        send(ADD, 16'h8FFF, 16'h8000);
        @(negedge clk);
        check("add_latency", 32'(out_valid), 32'd1);

        // SUB then ADC back-to-back; ADC consumes the borrow left by SUB
        @(posedge clk);
        #1;
        expect_result("sub", 16'hFFFE, 5'b10010);
        send(SUB, 16'h0005, 16'h0007);
        expect_result("adc", 16'h0003, 5'b00100);
        send(ADC, 16'h0001, 16'h0001);
        @(negedge clk);

        // MUL: 16 busy cycles, result on the 17th
        @(posedge clk);
        #1;
        expect_result("mul", 16'h0000, 5'b01111);
        send(MUL, 16'h0100, 16'h0100);
        n = 0;
        busy_cnt = 0;
        ready_cnt = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (busy) busy_cnt++;
            if (in_ready) ready_cnt++;
        end
        check("mul_latency", 32'(n), 32'd17);
        check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
        check("mul_in_ready_low", 32'(ready_cnt), 32'd0);

        // Backpressure on XOR, then retire and accept AND in the same cycle
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expect_result("xor", 16'hFF00, 5'b10100);
        send(XOR, 16'hFFFF, 16'h00FF);
        bad_z = 0;
        bad_v = 0;
        bad_r = 0;
        repeat (5) begin
            @(negedge clk);
            if (z !== 16'hFF00) bad_z++;
            if (out_valid !== 1'b1) bad_v++;
            if (in_ready !== 1'b0) bad_r++;
        end
        check("stall_z_stable", 32'(bad_z), 32'd0);
        check("stall_out_valid", 32'(bad_v), 32'd0);
        check("stall_in_ready", 32'(bad_r), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_result("and", 16'h0230, 5'b00000);
        send(AND, 16'h1234, 16'h0FF0);
        @(negedge clk);
        check("and_no_bubble", 32'(out_valid), 32'd1);

        // Shifts, including a zero shift amount
        @(posedge clk);
        #1;
        expect_result("shl", 16'h0002, 5'b00010);
        send(SHL, 16'h8001, 16'h0001);
        expect_result("shr", 16'h0001, 5'b00000);
        send(SHR, 16'h0001, 16'h0000);
        @(negedge clk);

        // Set carry_q, then reset in the middle of a MUL
        @(posedge clk);
        #1;
        expect_result("sub_borrow", 16'hFFFF, 5'b10110);
        send(SUB, 16'h0000, 16'h0001);
        @(negedge clk);
        @(posedge clk);
        #1;
        send(MUL, 16'h0003, 16'h0005);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ov_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("abort_no_output", 32'(ov_cnt), 32'd0);
        @(posedge clk);
        #1;
        expect_result("adc_after_reset", 16'h0002, 5'b00000);
        send(ADC, 16'h0001, 16'h0001);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
